// File: rtl/pc_redirect_ctrl.sv
// PC sequencing controller: picks next_pc and hold each cycle, arbitrates the
// trap/mret/branch/jump redirects and buffers a redirect that arrives under hold.
module pc_redirect_ctrl #(
    parameter int unsigned           ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]     RESET_ADDR = '0,
    parameter int unsigned           CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall_req,
    input  logic              imem_ready,
    output logic              imem_req,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_target,
    input  logic              mret_valid,
    input  logic [ADDR_W-1:0] mret_target,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              hold,
    output logic              cancel_if,
    output logic              cancel_id,
    output logic              misalign,
    output logic [CNT_W-1:0]  redir_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic [1:0]         pend_pri_q, pend_pri_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sel_valid;
    logic [1:0]         sel_pri;
    logic [ADDR_W-1:0]  sel_raw;
    logic [ADDR_W-1:0]  sel_pc;
    logic               sel_mis;
    logic [ADDR_W-1:0]  pc_inc;
    logic               fetch_on;
    logic               hold_eff;
    logic               take_new;
    logic [ADDR_W-1:0]  win_pc;
    logic [1:0]         win_pri;

    // Fixed-priority redirect select: trap > mret > branch > jump
    always_comb begin
        sel_valid = trap_valid | mret_valid | br_valid | jmp_valid;
        sel_pri   = 2'd0;
        sel_raw   = jmp_target;
        if (trap_valid) begin
            sel_pri = 2'd3;
            sel_raw = trap_target;
        end else if (mret_valid) begin
            sel_pri = 2'd2;
            sel_raw = mret_target;
        end else if (br_valid) begin
            sel_pri = 2'd1;
            sel_raw = br_target;
        end
    end

    assign sel_pc   = {sel_raw[ADDR_W-1:2], 2'b00};
    assign sel_mis  = |sel_raw[1:0];
    assign pc_inc   = pc + ADDR_W'(4);
    assign fetch_on = (state_q != BOOT);
    assign hold_eff = stall_req | (fetch_on & ~imem_ready) | (state_q == BOOT);

    // A same-cycle redirect beats the buffered one on equal or higher priority
    assign take_new = sel_valid & (~pend_valid_q | (sel_pri >= pend_pri_q));
    assign win_pc   = take_new ? sel_pc  : pend_pc_q;
    assign win_pri  = take_new ? sel_pri : pend_pri_q;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_pri_d   = pend_pri_q;
        cnt_d        = cnt_q;
        next_pc      = pc_inc;
        hold         = hold_eff;
        imem_req     = 1'b1;
        cancel_if    = 1'b0;
        cancel_id    = 1'b0;
        misalign     = 1'b0;

        unique case (state_q)
            BOOT: begin
                hold     = 1'b1;
                imem_req = 1'b0;
                next_pc  = RESET_ADDR;
                state_d  = RUN;
            end
            RUN: begin
                if (sel_valid) begin
                    cancel_if = 1'b1;
                    cancel_id = (sel_pri != 2'd0);
                    misalign  = sel_mis;
                    if (!hold_eff) begin
                        next_pc = sel_pc;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = sel_pc;
                        pend_pri_d   = sel_pri;
                        state_d      = PEND;
                    end
                end
            end
            PEND: begin
                cancel_if = 1'b1;
                cancel_id = (win_pri != 2'd0);
                misalign  = take_new & sel_mis;
                if (!hold_eff) begin
                    next_pc      = win_pc;
                    cnt_d        = cnt_q + CNT_W'(1);
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else if (take_new) begin
                    pend_pc_d  = sel_pc;
                    pend_pri_d = sel_pri;
                end
            end
            default: begin
                hold     = 1'b1;
                imem_req = 1'b0;
                next_pc  = RESET_ADDR;
                state_d  = BOOT;
            end
        endcase

        // Outputs take their reset values as soon as rstn falls, not at the next edge
        if (!rstn) begin
            hold      = 1'b1;
            imem_req  = 1'b0;
            next_pc   = RESET_ADDR;
            cancel_if = 1'b0;
            cancel_id = 1'b0;
            misalign  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            pend_pri_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_pri_q   <= pend_pri_d;
            cnt_q        <= cnt_d;
        end
    end

    assign redir_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: expectations queued at drive time, compared at negedge.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc;
    logic        stall_req, imem_ready, imem_req;
    logic        trap_valid, mret_valid, br_valid, jmp_valid;
    logic [31:0] trap_target, mret_target, br_target, jmp_target;
    logic [31:0] next_pc;
    logic        hold, cancel_if, cancel_id, misalign;
    logic [1:0]  redir_cnt;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [1:0]  exp_cnt = 2'd0;

    typedef struct {
        string       tag;
        bit          chk_npc;
        logic [31:0] npc;
        logic        hold, req, cif, cid, mis;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];

    pc_redirect_ctrl #(
        .ADDR_W    (32),
        .RESET_ADDR(32'h0000_0000),
        .CNT_W     (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .stall_req  (stall_req),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .trap_valid (trap_valid),
        .trap_target(trap_target),
        .mret_valid (mret_valid),
        .mret_target(mret_target),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .next_pc    (next_pc),
        .hold       (hold),
        .cancel_if  (cancel_if),
        .cancel_id  (cancel_id),
        .misalign   (misalign),
        .redir_cnt  (redir_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit chk_npc, input logic [31:0] npc,
                              input logic h, input logic r, input logic ci, input logic cd,
                              input logic m, input bit apply);
        exp_t e;
        e.tag = tag; e.chk_npc = chk_npc; e.npc = npc;
        e.hold = h; e.req = r; e.cif = ci; e.cid = cd; e.mis = m; e.cnt = exp_cnt;
        sb_q.push_back(e);
        if (apply) exp_cnt = exp_cnt + 2'd1;
    endtask

    // Advance to just after the next rising edge; redirect inputs are one-cycle pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        trap_valid = 1'b0; mret_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk_npc) check({e.tag, ".next_pc"}, next_pc, e.npc);
            check({e.tag, ".hold"},      {31'd0, hold},      {31'd0, e.hold});
            check({e.tag, ".imem_req"},  {31'd0, imem_req},  {31'd0, e.req});
            check({e.tag, ".cancel_if"}, {31'd0, cancel_if}, {31'd0, e.cif});
            check({e.tag, ".cancel_id"}, {31'd0, cancel_id}, {31'd0, e.cid});
            check({e.tag, ".misalign"},  {31'd0, misalign},  {31'd0, e.mis});
            check({e.tag, ".redir_cnt"}, {30'd0, redir_cnt}, {30'd0, e.cnt});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1; pc = 32'h0; stall_req = 1'b0; imem_ready = 1'b1;
        trap_valid = 1'b0; mret_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
        trap_target = '0; mret_target = '0; br_target = '0; jmp_target = '0;
        #1 rstn = 1'b0;
        #1;
        check("rst.hold",     {31'd0, hold},      32'd1);
        check("rst.imem_req", {31'd0, imem_req},  32'd0);
        check("rst.next_pc",  next_pc,            32'h0);
        check("rst.cnt",      {30'd0, redir_cnt}, 32'd0);

        // Reset release: one BOOT cycle ignoring redirects, then sequential fetch
        cyc(); rstn = 1'b1; trap_valid = 1'b1; trap_target = 32'h123;
        expect_out("boot", 1, 32'h0, 1, 0, 0, 0, 0, 0);
        cyc(); pc = 32'h0;
        expect_out("run0", 1, 32'h4, 0, 1, 0, 0, 0, 0);
        cyc(); pc = 32'h4;
        expect_out("run4", 1, 32'h8, 0, 1, 0, 0, 0, 0);

        // Simultaneous branch and jump: branch wins
        cyc(); pc = 32'h100; br_valid = 1'b1; br_target = 32'h200; jmp_valid = 1'b1; jmp_target = 32'h300;
        expect_out("simul", 1, 32'h200, 0, 1, 1, 1, 0, 1);
        cyc(); pc = 32'h200;
        expect_out("after_simul", 1, 32'h204, 0, 1, 0, 0, 0, 0);

        // Held branch: capture, three held PEND cycles, apply on release
        cyc(); stall_req = 1'b1; br_valid = 1'b1; br_target = 32'h400;
        expect_out("hb_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc();
            expect_out("hb_pend", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        end
        cyc(); stall_req = 1'b0;
        expect_out("hb_apply", 1, 32'h400, 0, 1, 1, 1, 0, 1);
        cyc(); pc = 32'h400;
        expect_out("hb_run", 1, 32'h404, 0, 1, 0, 0, 0, 0);

        // Trap overrides a pending branch
        cyc(); stall_req = 1'b1; br_valid = 1'b1; br_target = 32'h400;
        expect_out("pt_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); trap_valid = 1'b1; trap_target = 32'h80;
        expect_out("pt_trap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); stall_req = 1'b0;
        expect_out("pt_apply", 1, 32'h80, 0, 1, 1, 1, 0, 1);

        // Jump arriving over a pending trap is dropped
        cyc(); pc = 32'h80; stall_req = 1'b1; trap_valid = 1'b1; trap_target = 32'h80;
        expect_out("pj_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); jmp_valid = 1'b1; jmp_target = 32'h501;
        expect_out("pj_drop", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); stall_req = 1'b0;
        expect_out("pj_apply", 1, 32'h80, 0, 1, 1, 1, 0, 1);

        // Apply cycle with a higher-priority same-cycle mret
        cyc(); stall_req = 1'b1; br_valid = 1'b1; br_target = 32'h600;
        expect_out("pm_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); stall_req = 1'b0; mret_valid = 1'b1; mret_target = 32'h700;
        expect_out("pm_apply", 1, 32'h700, 0, 1, 1, 1, 0, 1);

        // Fetch not ready also holds and buffers the redirect
        cyc(); pc = 32'h700; imem_ready = 1'b0; br_valid = 1'b1; br_target = 32'h900;
        expect_out("rdy_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); imem_ready = 1'b1;
        expect_out("rdy_apply", 1, 32'h900, 0, 1, 1, 1, 0, 1);

        // Misaligned jump: target truncated, misalign pulse, ID not cancelled
        cyc(); pc = 32'h900; jmp_valid = 1'b1; jmp_target = 32'h202;
        expect_out("mis_jmp", 1, 32'h200, 0, 1, 1, 0, 1, 1);
        cyc(); pc = 32'h200;
        expect_out("mis_after", 1, 32'h204, 0, 1, 0, 0, 0, 0);

        // Asynchronous reset while PEND, then release without applying the buffer
        cyc(); stall_req = 1'b1; br_valid = 1'b1; br_target = 32'h800;
        expect_out("rp_cap", 0, 32'h0, 1, 1, 1, 1, 0, 0);
        cyc(); rstn = 1'b0;
        #1;
        check("rp.hold",      {31'd0, hold},      32'd1);
        check("rp.imem_req",  {31'd0, imem_req},  32'd0);
        check("rp.next_pc",   next_pc,            32'h0);
        check("rp.cancel_if", {31'd0, cancel_if}, 32'd0);
        check("rp.cancel_id", {31'd0, cancel_id}, 32'd0);
        check("rp.cnt",       {30'd0, redir_cnt}, 32'd0);
        exp_cnt = 2'd0;
        cyc(); rstn = 1'b1; stall_req = 1'b0;
        expect_out("rp_boot", 1, 32'h0, 1, 0, 0, 0, 0, 0);
        cyc(); pc = 32'h0;
        expect_out("rp_run", 1, 32'h4, 0, 1, 0, 0, 0, 0);

        // Five applied redirects on a 2-bit counter end at 1
        for (int unsigned i = 0; i < 5; i++) begin
            cyc(); pc = 32'h1000 + 32'(i * 4); jmp_valid = 1'b1; jmp_target = 32'h2000 + 32'(i * 16);
            expect_out("wrap_jmp", 1, 32'h2000 + 32'(i * 16), 0, 1, 1, 0, 0, 1);
        end
        cyc(); pc = 32'h3000;
        expect_out("wrap_end", 1, 32'h3004, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("cnt_wrap", {30'd0, redir_cnt}, 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Front-end sequencing controller for the program counter. Each cycle it computes `next_pc` and `hold`, and arbitrates the redirect sources: trap, mret, EX branch and ID jump. A redirect that arrives while the front end is held is buffered and applied when the hold lifts. The block also drives the IF/ID cancel signals and the instruction-memory fetch request. It sits between the hazard/CSR/execute logic and the program counter register.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width.
- `RESET_ADDR`, default 32'h0000_0000: boot PC.
- `CNT_W`, default 16: width of the redirect counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pc`  in  ADDR_W  current PC from the program counter register.
- `stall_req`  in  1  hazard-unit front-end stall.
- `imem_ready`  in  1  instruction memory accepts/returns the fetch this cycle.
- `imem_req`  out  1  fetch request for `pc`.
- `trap_valid`, `trap_target`  in  1, ADDR_W  trap redirect (priority 3).
- `mret_valid`, `mret_target`  in  1, ADDR_W  mret redirect (priority 2).
- `br_valid`, `br_target`  in  1, ADDR_W  EX branch/jalr redirect (priority 1).
- `jmp_valid`, `jmp_target`  in  1, ADDR_W  ID jal redirect (priority 0).
- `next_pc`  out  ADDR_W  value the PC register loads when `hold`=0.
- `hold`  out  1  PC register hold.
- `cancel_if`  out  1  squash the IF-stage instruction.
- `cancel_id`  out  1  squash the ID-stage instruction.
- `misalign`  out  1  one-cycle pulse when the winning target has bits [1:0] ≠ 0.
- `redir_cnt`  out  CNT_W  count of applied redirects; wraps.

## Operation
States: BOOT, RUN, PEND.

Reset values: state=BOOT, `pend_valid`=0, `pend_pc`=0, `pend_pri`=0, `redir_cnt`=0.

Redirect selection:
- `sel` is the highest-priority asserted redirect input.
- Its target is used with bits [1:0] forced to 0. `misalign` is asserted in the same cycle if the original bits were non-zero.

Effective hold: `hold_eff = stall_req | (imem_req & ~imem_ready) | (state==BOOT)`.

Per state:
- **BOOT**:
  - `hold`=1, `imem_req`=0, `next_pc`=RESET_ADDR, cancels=0.
  - Redirect inputs are ignored.
  - Goes to RUN after exactly one cycle.
- **RUN**:
  - `imem_req`=1, `hold`=`hold_eff`.
  - No `sel`: `next_pc = pc + 4`, modulo 2^ADDR_W.
  - `sel` and `~hold_eff`: the redirect is applied; `next_pc`=target and `redir_cnt` increments.
  - `sel` and `hold_eff`: the target is captured into `pend_pc`/`pend_pri`, `pend_valid`=1, and the state goes to PEND.
- **PEND**:
  - `imem_req`=1, `hold`=`hold_eff`.
  - A new `sel` with priority ≥ `pend_pri` overwrites the pending entry. A lower-priority `sel` is dropped.
  - First cycle with `~hold_eff`: `next_pc` = winner of the pending entry and any same-cycle `sel`. The higher priority wins; on a tie the new `sel` wins.
  - On that apply cycle `redir_cnt` increments, `pend_valid` clears and the state returns to RUN.

Cancels:
- `cancel_if`=1 and `cancel_id`=1 in the capture cycle, in every PEND cycle, and in the apply cycle.
- Exception: when the redirect being applied or captured is `jmp` (priority 0), `cancel_id`=0, because the ID instruction is the jump itself.

Reset mid-operation:
- `rstn` low asynchronously forces BOOT and clears the pending entry and counter.
- While `rstn` is low: `hold`=1, `imem_req`=0, `next_pc`=RESET_ADDR, `cancel_if`=`cancel_id`=`misalign`=0.

## Timing
- All outputs except the state, pending and counter registers are combinational from inputs and current state. Zero-cycle decision; the PC updates on the next edge.
- Unheld redirect: asserted in cycle N, PC equals the target after edge N.
- Held redirect: captured in cycle N, applied in the first cycle M>N with `hold_eff`=0, PC equals the target after edge M.
- Redirect inputs are single-cycle pulses; the block does not require them to be held.
- `redir_cnt` updates at the apply edge and wraps from 2^CNT_W−1 to 0.

## Test plan
- **Reset release:** `rstn` 0→1 → one BOOT cycle with `hold`=1 and `imem_req`=0. Then `next_pc` goes 0x0, 0x4, 0x8 on successive cycles, with `imem_ready`=1 and no stall.
- **Simultaneous redirects:** `pc`=0x100, `br_valid` with 0x200 and `jmp_valid` with 0x300 in the same cycle → `next_pc`=0x200, `cancel_if`=`cancel_id`=1, `redir_cnt`=1.
- **Held branch:** `br_target`=0x400 while `stall_req`=1 for 3 cycles → PEND for 3 cycles with cancels high. In the first cycle `stall_req`=0, `next_pc`=0x400.
- **Priority while pending:**
  - In PEND with br 0x400, `trap_valid` with 0x80 arrives → applied target is 0x80.
  - In PEND with trap 0x80, `jmp_valid` with 0x500 arrives → it is ignored; applied target is 0x80.
- **Misaligned / jmp-only cancel:** `jmp_target`=0x202 unheld → `next_pc`=0x200, `misalign` pulses one cycle, `cancel_if`=1, `cancel_id`=0.
- **Reset in PEND and counter wrap:**
  - Assert `rstn`=0 while in PEND → outputs return to reset values immediately, with no edge required, and no pending redirect is applied after release.
  - With CNT_W=2, apply 5 redirects → `redir_cnt`=1.
